// File: rtl/ext_obi_demux_pkg.sv
// Shared types and constants for the external OBI region demultiplexer.
//   ERR_RDATA        read data returned for unmapped accesses
//   tgt_idx_t        target index; value NUM_REGIONS encodes the error target
//   addr_map_rule_t  {idx, start_addr, end_addr} rule, end_addr exclusive
//   DEFAULT_RULES    consecutive 2 MiB regions from EXT_SLAVE_START_ADDRESS
package ext_obi_demux_pkg;

  localparam int unsigned MAX_REGIONS = 8;

  localparam logic [31:0] EXT_SLAVE_START_ADDRESS = 32'hF000_0000;
  localparam logic [31:0] EXT_REGION_SIZE         = 32'h0020_0000;
  localparam logic [31:0] ERR_RDATA               = 32'hBADC_AB1E;

  // Sized for the largest supported region count so that one type serves
  // every instance; the top uses value NUM_REGIONS as the error target.
  localparam int unsigned TGT_W = $clog2(MAX_REGIONS + 1);
  typedef logic [TGT_W-1:0] tgt_idx_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  typedef addr_map_rule_t [MAX_REGIONS-1:0] rule_array_t;

  function automatic rule_array_t default_rules();
    rule_array_t r;
    for (int unsigned i = 0; i < MAX_REGIONS; i++) begin
      r[i].idx        = i;
      r[i].start_addr = EXT_SLAVE_START_ADDRESS + i * EXT_REGION_SIZE;
      r[i].end_addr   = r[i].start_addr + EXT_REGION_SIZE;
    end
    return r;
  endfunction

  localparam rule_array_t DEFAULT_RULES = default_rules();

endpackage

// File: rtl/ext_obi_tgt_fifo.sv
// Outstanding-target FIFO for the OBI region demux.
//   clk_i, rst_i      clock, asynchronous active-high reset (empties FIFO)
//   push_i, data_i    write one target index
//   pop_i             drop the head entry
//   full_o, empty_o   occupancy flags
//   head_o            oldest entry (valid when !empty_o)
//   last_o            most recently pushed entry (valid when !empty_o)
// Push and pop in the same cycle are allowed even when full.
module ext_obi_tgt_fifo
  import ext_obi_demux_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  tgt_idx_t data_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output tgt_idx_t head_o,
  output tgt_idx_t last_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  tgt_idx_t    mem_q [DEPTH];
  logic [PW:0] wr_q, rd_q;
  tgt_idx_t    last_q;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head_o  = mem_q[rd_q[PW-1:0]];
  assign last_o  = last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_q[PW-1:0]] <= data_i;
        wr_q                <= wr_q + PTR_ONE;
        last_q              <= data_i;
      end
      if (pop_i) begin
        rd_q <= rd_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ext_obi_region_demux.sv
// OBI request demultiplexer: one master port to NUM_REGIONS slave ports.
//   m_*      master request (req/we/addr/wdata/be), grant and response
//   s_req_o  one-hot per-slave request; addr/wdata/we/be broadcast to all
//   s_gnt_i, s_rvalid_i, s_rdata_i  per-slave grant and response
//   err_clr_i  synchronous clear of err_cnt_o
//   err_cnt_o  saturating count of accepted unmapped accesses
// Targets are decoded from ADDR_RULES (lowest matching rule wins); misses go
// to an internal error target answered in order with ERR_RDATA / m_err_o.
// Responses stay in order because a request whose target differs from the
// last issued one waits until the outstanding FIFO drains.
module ext_obi_region_demux
  import ext_obi_demux_pkg::*;
#(
  parameter int unsigned                     NUM_REGIONS     = 2,
  parameter addr_map_rule_t [NUM_REGIONS-1:0] ADDR_RULES     = DEFAULT_RULES[NUM_REGIONS-1:0],
  parameter int unsigned                     MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      m_req_i,
  input  logic                      m_we_i,
  input  logic [31:0]               m_addr_i,
  input  logic [31:0]               m_wdata_i,
  input  logic [3:0]                m_be_i,
  output logic                      m_gnt_o,
  output logic                      m_rvalid_o,
  output logic [31:0]               m_rdata_o,
  output logic                      m_err_o,
  output logic [NUM_REGIONS-1:0]    s_req_o,
  output logic [31:0]               s_addr_o,
  output logic [31:0]               s_wdata_o,
  output logic                      s_we_o,
  output logic [3:0]                s_be_o,
  input  logic [NUM_REGIONS-1:0]    s_gnt_i,
  input  logic [NUM_REGIONS-1:0]    s_rvalid_i,
  input  logic [NUM_REGIONS*32-1:0] s_rdata_i,
  input  logic                      err_clr_i,
  output logic [15:0]               err_cnt_o
);

  localparam tgt_idx_t TGT_ERR = tgt_idx_t'(NUM_REGIONS);

  tgt_idx_t    dec_tgt;
  logic        dec_hit;
  logic        sel_gnt;
  tgt_idx_t    fifo_head, fifo_last;
  logic        fifo_full, fifo_empty;
  logic        head_err, head_rvalid;
  logic [31:0] head_rdata;
  logic        pop, acc, push;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] err_rdata_q;

  // Address decode: first hit in ascending rule order.
  always_comb begin
    dec_hit = 1'b0;
    dec_tgt = TGT_ERR;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!dec_hit && m_addr_i >= ADDR_RULES[i].start_addr
                   && m_addr_i <  ADDR_RULES[i].end_addr) begin
        dec_hit = 1'b1;
        dec_tgt = tgt_idx_t'(ADDR_RULES[i].idx);
      end
    end
  end

  always_comb begin
    sel_gnt = 1'b0;
    for (int unsigned j = 0; j < NUM_REGIONS; j++) begin
      if (dec_tgt == tgt_idx_t'(j)) sel_gnt = s_gnt_i[j];
    end
  end

  always_comb begin
    head_rvalid = 1'b0;
    head_rdata  = '0;
    for (int unsigned j = 0; j < NUM_REGIONS; j++) begin
      if (fifo_head == tgt_idx_t'(j)) begin
        head_rvalid = s_rvalid_i[j];
        head_rdata  = s_rdata_i[j*32 +: 32];
      end
    end
  end

  assign head_err = (fifo_head == TGT_ERR);

  // An error entry retires as soon as it reaches the head.
  assign pop  = !fifo_empty && (head_err || head_rvalid);
  // A pop in this cycle frees a slot, so a full FIFO may still accept.
  assign acc  = m_req_i && (!fifo_full || pop)
                        && (fifo_empty || dec_tgt == fifo_last);
  assign push = acc && (!dec_hit || sel_gnt);

  always_comb begin
    s_req_o = '0;
    for (int unsigned j = 0; j < NUM_REGIONS; j++) begin
      s_req_o[j] = acc && (dec_tgt == tgt_idx_t'(j));
    end
  end

  assign m_gnt_o   = push;
  assign s_addr_o  = m_addr_i;
  assign s_wdata_o = m_wdata_i;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;

  assign m_rvalid_o = pop;
  assign m_err_o    = !fifo_empty && head_err;
  assign m_rdata_o  = fifo_empty ? '0 : (head_err ? err_rdata_q : head_rdata);

  ext_obi_tgt_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tgt_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (dec_tgt),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .last_o  (fifo_last)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (acc && !dec_hit && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q   <= '0;
      err_rdata_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      if (push && !dec_hit) err_rdata_q <= ERR_RDATA;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_ext_obi_region_demux.sv
// Self-checking bench for ext_obi_region_demux (2 regions, 4 outstanding).
module tb_ext_obi_region_demux;
  import ext_obi_demux_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [31:0]      m_addr, m_wdata, m_rdata;
  logic [3:0]       m_be;
  logic [NR-1:0]    s_req, s_gnt, s_rvalid;
  logic [31:0]      s_addr, s_wdata;
  logic             s_we;
  logic [3:0]       s_be;
  logic [NR*32-1:0] s_rdata;
  logic             err_clr;
  logic [15:0]      err_cnt;

  ext_obi_region_demux #(
    .NUM_REGIONS     (NR),
    .MAX_OUTSTANDING (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m_req_i    (m_req),
    .m_we_i     (m_we),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_be_i     (m_be),
    .m_gnt_o    (m_gnt),
    .m_rvalid_o (m_rvalid),
    .m_rdata_o  (m_rdata),
    .m_err_o    (m_err),
    .s_req_o    (s_req),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_we_o     (s_we),
    .s_be_o     (s_be),
    .s_gnt_i    (s_gnt),
    .s_rvalid_i (s_rvalid),
    .s_rdata_i  (s_rdata),
    .err_clr_i  (err_clr),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of issued targets (NR = error target) and counter.
  int q[$];
  int mcnt = 0;
  bit stray_ok = 1'b0;

  function automatic int ref_dec(input logic [31:0] a);
    longint unsigned s;
    for (int i = 0; i < NR; i++) begin
      s = 64'hF000_0000 + longint'(i) * 64'h20_0000;
      if (a >= s && a < s + 64'h20_0000) return i;
    end
    return NR;
  endfunction

  bit pv, p_pop, p_push, p_errinc, p_clr;
  int p_dec;

  always @(negedge clk) begin
    if (!rst) begin
      int dec, head;
      bit empty, pop, acc, gnt, er;
      logic [NR-1:0] sreq;
      logic [31:0] rd;
      dec   = ref_dec(m_addr);
      empty = (q.size() == 0);
      head  = empty ? -1 : q[0];
      pop   = !empty && (head == NR || s_rvalid[head]);
      acc   = m_req && (q.size() < DEPTH || pop) && (empty || dec == q[$]);
      gnt   = acc && (dec == NR || s_gnt[dec]);
      sreq  = (acc && dec < NR) ? NR'(1 << dec) : '0;
      er    = !empty && head == NR;
      chk("gnt", 32'(m_gnt), 32'(gnt));
      chk("s_req", 32'(s_req), 32'(sreq));
      chk("rvalid", 32'(m_rvalid), 32'(pop));
      chk("err", 32'(m_err), 32'(er));
      chk("err_cnt", 32'(err_cnt), 32'(mcnt));
      chk("s_addr", s_addr, m_addr);
      chk("s_wdata", s_wdata, m_wdata);
      chk("s_we_be", {27'd0, s_we, s_be}, {27'd0, m_we, m_be});
      if (pop) begin
        rd = (head == NR) ? 32'hBADCAB1E : s_rdata[head*32 +: 32];
        chk("rdata", m_rdata, rd);
      end
      if (s_rvalid != '0 && !stray_ok) begin
        n_tests++;
        if (empty || head == NR || s_rvalid != NR'(1 << head)) begin
          n_fail++;
          $display("FAIL stray_rvalid: got %b with model head %0d", s_rvalid, head);
        end
      end
      p_pop = pop; p_push = gnt; p_dec = dec;
      p_errinc = acc && dec == NR; p_clr = err_clr;
      pv = 1'b1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      mcnt = 0;
      pv   = 1'b0;
    end else if (pv) begin
      if (p_pop) void'(q.pop_front());
      if (p_push) q.push_back(p_dec);
      if (p_clr) mcnt = 0;
      else if (p_errinc && mcnt < 65535) mcnt++;
      pv = 1'b0;
    end
  end

  task automatic idle();
    m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_gnt = '0; s_rvalid = '0; s_rdata = '0; err_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, 32'(m_gnt), 0);
    chk({tag, "_rvalid"}, 32'(m_rvalid), 0);
    chk({tag, "_err"}, 32'(m_err), 0);
    chk({tag, "_sreq"}, 32'(s_req), 0);
    chk({tag, "_rdata"}, m_rdata, 0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 0);
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    samp();
    chk_quiet("reset");
    tick(); rst = 0;

    // Write region 0, then read region 1 (waits for the write response).
    m_req = 1; m_we = 1; m_addr = 32'hF000_0010; m_wdata = 32'hCAFE_0001; m_be = 4'hF;
    s_gnt = 2'b11;
    samp(); chk("t1_sreq_w", 32'(s_req), 32'h1); chk("t1_gnt_w", 32'(m_gnt), 1);
    tick(); m_we = 0; m_addr = 32'hF020_0004; s_rvalid = 2'b01;
    samp(); chk("t1_stall", 32'(m_gnt), 0); chk("t1_wresp", 32'(m_rvalid), 1);
    tick(); s_rvalid = 2'b00;
    samp(); chk("t1_sreq_r", 32'(s_req), 32'h2); chk("t1_gnt_r", 32'(m_gnt), 1);
    tick(); m_req = 0; s_rvalid = 2'b10; s_rdata = {32'h1234_5678, 32'hDEAD_0000};
    samp(); chk("t1_rvalid", 32'(m_rvalid), 1); chk("t1_rdata", m_rdata, 32'h1234_5678);
    chk("t1_err", 32'(m_err), 0);
    tick(); idle();

    // Fill the FIFO with four region-0 reads, fifth waits for a pop.
    m_req = 1; m_addr = 32'hF000_0100; s_gnt = 2'b01;
    for (int k = 0; k < 4; k++) begin
      samp(); chk("t2_fill_gnt", 32'(m_gnt), 1);
      tick(); m_addr = m_addr + 32'd4;
    end
    samp(); chk("t2_full_gnt", 32'(m_gnt), 0); chk("t2_full_sreq", 32'(s_req), 0);
    tick(); s_rvalid = 2'b01; s_rdata = {32'h0, 32'h0000_0A11};
    samp(); chk("t2_pushpop_gnt", 32'(m_gnt), 1); chk("t2_pushpop_rv", 32'(m_rvalid), 1);
    repeat (4) begin
      tick(); m_req = 0;
      samp(); chk("t2_drain", 32'(m_rvalid), 1);
    end
    tick(); idle();

    // Target switch waits for the earlier response; order preserved.
    m_req = 1; m_addr = 32'hF000_0000; s_gnt = 2'b11;
    samp(); chk("t3_gnt0", 32'(m_gnt), 1);
    tick(); m_addr = 32'hF020_0000;
    samp(); chk("t3_wait_a", 32'(m_gnt), 0);
    tick();
    samp(); chk("t3_wait_b", 32'(m_gnt), 0);
    tick(); s_rvalid = 2'b01; s_rdata = {32'hBBBB_0002, 32'hAAAA_0001};
    samp(); chk("t3_wait_c", 32'(m_gnt), 0); chk("t3_rdata_a", m_rdata, 32'hAAAA_0001);
    tick(); s_rvalid = 2'b00;
    samp(); chk("t3_gnt1", 32'(m_gnt), 1); chk("t3_sreq1", 32'(s_req), 32'h2);
    tick(); m_req = 0; s_rvalid = 2'b10;
    samp(); chk("t3_rdata_b", m_rdata, 32'hBBBB_0002);
    tick(); idle();

    // Three back-to-back unmapped reads.
    err_clr = 1;
    tick(); err_clr = 0; m_req = 1; m_addr = 32'h0000_1000;
    samp(); chk("t4_gnt_n", 32'(m_gnt), 1); chk("t4_rv_n", 32'(m_rvalid), 0);
    repeat (2) begin
      tick();
      samp(); chk("t4_gnt", 32'(m_gnt), 1); chk("t4_rv", 32'(m_rvalid), 1);
      chk("t4_rdata", m_rdata, 32'hBADC_AB1E); chk("t4_err", 32'(m_err), 1);
    end
    tick(); m_req = 0;
    samp(); chk("t4_rv_n3", 32'(m_rvalid), 1); chk("t4_err_n3", 32'(m_err), 1);
    chk("t4_cnt", 32'(err_cnt), 3);
    tick();
    samp(); chk("t4_rv_end", 32'(m_rvalid), 0);
    tick(); idle();

    // Saturation, then clear with priority over an increment.
    err_clr = 1;
    tick(); err_clr = 0; m_req = 1; m_addr = 32'h0000_2000;
    repeat (65535) tick();
    samp(); chk("t5_max", 32'(err_cnt), 32'hFFFF);
    tick(); m_req = 0;
    samp(); chk("t5_sat", 32'(err_cnt), 32'hFFFF);
    tick(); m_req = 1; err_clr = 1;
    samp(); chk("t5_clr_gnt", 32'(m_gnt), 1);
    tick(); m_req = 0; err_clr = 0;
    samp(); chk("t5_clr", 32'(err_cnt), 0);
    tick(); idle();

    // Reset with two outstanding entries.
    m_req = 1; m_addr = 32'hF000_0040; s_gnt = 2'b01;
    tick(); m_addr = 32'hF000_0044;
    tick(); rst = 1; idle();
    samp(); chk_quiet("t6_in_rst");
    tick(); rst = 0;
    samp(); chk_quiet("t6_after_rst");
    tick(); stray_ok = 1; s_rvalid = 2'b01; s_rdata = {32'h0, 32'h5555_AAAA};
    samp(); chk("t6_stray_ignored", 32'(m_rvalid), 0);
    tick(); s_rvalid = 2'b00; stray_ok = 0; m_req = 1; m_addr = 32'hF020_0000; s_gnt = 2'b10;
    samp(); chk("t6_empty_accept", 32'(m_gnt), 1);
    tick(); m_req = 0; s_gnt = 2'b00; s_rvalid = 2'b10;
    samp(); chk("t6_resp", 32'(m_rvalid), 1);
    tick(); idle();

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      m_req = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: m_addr = 32'hF000_0000;
        1: m_addr = 32'hF01F_FFFF;
        2: m_addr = 32'hF020_0000;
        3: m_addr = 32'hF03F_FFFF;
        4: m_addr = 32'hF040_0000;
        5: m_addr = 32'hEFFF_FFFF;
        6: m_addr = 32'hF000_0000 + $urandom_range(0, 32'h3F_FFFF);
        default: m_addr = $urandom;
      endcase
      m_we = 1'($urandom); m_wdata = $urandom; m_be = 4'($urandom);
      s_gnt = NR'($urandom);
      s_rdata = {$urandom, $urandom};
      s_rvalid = '0;
      if (q.size() > 0 && q[0] != NR && $urandom_range(0, 1) == 1) s_rvalid[q[0]] = 1'b1;
      err_clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
